serial_adder_ctrl: RTL and testbench

- Bit-serial W-bit adder controller that streams operands LSB-first through a single internal full-adder cell, one bit per clock.
- Holds the running carry in a flip-flop, shifts sum bits into a result register, and presents sum and carry-out to downstream.
- Sits directly upstream of and around the ripple adder cell. It supplies the cell's x/y/carry-in inputs each cycle and consumes its sum and carry outputs.
- Trades W cycles of latency for one adder cell of area.

---
 rtl/serial_adder_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit adder controller: operands stream LSB-first through one
// full-adder cell, one bit per clock, with the carry held in a flop between bits.
module serial_adder_ctrl #(
  parameter int W = 8
) (
  input  logic         in_clk,
  input  logic         in_rst,
  input  logic         in_valid,
  output logic         out_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         in_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   res_q, res_d;
  logic           cout_q, cout_d;

  logic           fa_s;
  logic           fa_c;
  logic [W-1:0]   sum_shift;

  // Single full-adder cell fed from the LSBs of the operand shifters.
  always_comb begin
    fa_s = a_q[0] ^ b_q[0] ^ carry_q;
    fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    // Shift-then-insert form stays legal for W=1, where sum_q[W-1:1] would not be.
    sum_shift        = sum_q >> 1;
    sum_shift[W-1]   = fa_s;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    res_d   = res_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = sum_shift;
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          valid_d = 1'b1;
          res_d   = sum_shift;
          cout_d  = fa_c;
        end
      end
      DONE: begin
        if (in_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
    end
  end

  assign out_ready = (state_q == IDLE) & ~in_rst;
  assign out_valid = valid_q;
  assign out_sum   = res_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: W=8 and W=1 instances.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  int           cyc;
  int           tests_run;
  int           tests_failed;

  logic         v8, rdy8, ovalid8, iready8, cin8, cout8;
  logic [W-1:0] a8, b8, sum8;

  logic         v1, rdy1, ovalid1, iready1, cin1, cout1;
  logic [0:0]   a1, b1, sum1;

  serial_adder_ctrl #(.W(W)) u_dut8 (
    .in_clk    (clk),
    .in_rst    (rst),
    .in_valid  (v8),
    .out_ready (rdy8),
    .in_a      (a8),
    .in_b      (b8),
    .in_cin    (cin8),
    .out_valid (ovalid8),
    .in_ready  (iready8),
    .out_sum   (sum8),
    .out_cout  (cout8)
  );

  serial_adder_ctrl #(.W(1)) u_dut1 (
    .in_clk    (clk),
    .in_rst    (rst),
    .in_valid  (v1),
    .out_ready (rdy1),
    .in_a      (a1),
    .in_b      (b1),
    .in_cin    (cin1),
    .out_valid (ovalid1),
    .in_ready  (iready1),
    .out_sum   (sum1),
    .out_cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (rdy8 !== 1'b0) begin tests_failed++; $display("FAIL reset_ready8 got %b exp 0", rdy8); end
    tests_run++;
    if (ovalid8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out8 got v=%b s=%h c=%b exp v=0 s=00 c=0", ovalid8, sum8, cout8);
    end
    tests_run++;
    if (rdy1 !== 1'b0 || ovalid1 !== 1'b0 || sum1 !== 1'b0 || cout1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out1 got r=%b v=%b s=%b c=%b exp all 0", rdy1, ovalid1, sum1, cout1);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (rdy8 !== 1'b1 || rdy1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready got r8=%b r1=%b exp 1 1", rdy8, rdy1);
    end
  endtask

  // Each vector: accept, check latency of exactly W edges, result, then return to IDLE.
  task automatic test_arith();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    logic [W-1:0] es [3];
    logic         ec [3];
    va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0; es[0] = 8'h00; ec[0] = 1'b1;
    va[1] = 8'h5A; vb[1] = 8'hA5; vc[1] = 1'b1; es[1] = 8'h00; ec[1] = 1'b1;
    va[2] = 8'h03; vb[2] = 8'h04; vc[2] = 1'b0; es[2] = 8'h07; ec[2] = 1'b0;
    iready8 = 1'b1;
    for (int unsigned t = 0; t < 3; t++) begin
      a8 = va[t]; b8 = vb[t]; cin8 = vc[t]; v8 = 1'b1;
      tick();
      v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      tests_run++;
      if (rdy8 !== 1'b0) begin tests_failed++; $display("FAIL arith%0d_busy got ready=%b exp 0", t, rdy8); end
      for (int unsigned i = 1; i < W; i++) begin
        tick();
        if (ovalid8 !== 1'b0) begin
          tests_run++; tests_failed++;
          $display("FAIL arith%0d_early_valid at cycle %0d got 1 exp 0", t, i);
        end
      end
      tick();
      tests_run++;
      if (ovalid8 !== 1'b1 || sum8 !== es[t] || cout8 !== ec[t]) begin
        tests_failed++;
        $display("FAIL arith%0d_result got v=%b s=%h c=%b exp v=1 s=%h c=%b",
                 t, ovalid8, sum8, cout8, es[t], ec[t]);
      end
      tick();
      tests_run++;
      if (ovalid8 !== 1'b0 || rdy8 !== 1'b1) begin
        tests_failed++;
        $display("FAIL arith%0d_handshake got v=%b r=%b exp v=0 r=1", t, ovalid8, rdy8);
      end
    end
  endtask

  task automatic test_backpressure();
    iready8 = 1'b0;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    for (int unsigned i = 0; i < W; i++) tick();
    tests_run++;
    if (ovalid8 !== 1'b1 || sum8 !== 8'h46 || cout8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_result got v=%b s=%h c=%b exp v=1 s=46 c=0", ovalid8, sum8, cout8);
    end
    for (int unsigned i = 0; i < 5; i++) begin
      v8 = 1'b1; a8 = 8'hAA; b8 = 8'hBB;
      tick();
      tests_run++;
      if (ovalid8 !== 1'b1 || sum8 !== 8'h46 || cout8 !== 1'b0 || rdy8 !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold%0d got v=%b s=%h c=%b r=%b exp v=1 s=46 c=0 r=0",
                 i, ovalid8, sum8, cout8, rdy8);
      end
    end
    v8 = 1'b0;
    iready8 = 1'b1;
    tick();
    tests_run++;
    if (ovalid8 !== 1'b0 || rdy8 !== 1'b1 || sum8 !== 8'h46) begin
      tests_failed++;
      $display("FAIL bp_release got v=%b r=%b s=%h exp v=0 r=1 s=46", ovalid8, rdy8, sum8);
    end
  endtask

  task automatic test_reset_mid();
    iready8 = 1'b1;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if (ovalid8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0 || rdy8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_out got v=%b s=%h c=%b r=%b exp v=0 s=00 c=0 r=0",
               ovalid8, sum8, cout8, rdy8);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (rdy8 !== 1'b1) begin tests_failed++; $display("FAIL rstmid_idle got ready=%b exp 1", rdy8); end
    for (int unsigned i = 0; i < W + 2; i++) begin
      tick();
      if (ovalid8 !== 1'b0) begin
        tests_run++; tests_failed++;
        $display("FAIL rstmid_ghost_valid at cycle %0d got 1 exp 0", i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int  acc1, acc2, r1c, r2c;
    bit  got1, got2, pend;
    iready8 = 1'b1;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; v8 = 1'b1;
    tick();
    acc1 = cyc;
    a8 = 8'h7F; b8 = 8'h01;
    got1 = 0; got2 = 0; acc2 = -1; r1c = -1; r2c = -1;
    for (int i = 0; i < 40 && !got2; i++) begin
      pend = rdy8 & v8;
      tick();
      if (pend && acc2 < 0) begin
        acc2 = cyc;
        v8 = 1'b0; a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b1;
      end
      if (ovalid8 && !got1) begin
        got1 = 1; r1c = cyc;
        tests_run++;
        if (sum8 !== 8'h30 || cout8 !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_res1 got s=%h c=%b exp s=30 c=0", sum8, cout8);
        end
      end else if (ovalid8 && got1 && acc2 >= 0 && !got2) begin
        got2 = 1; r2c = cyc;
        tests_run++;
        if (sum8 !== 8'h80 || cout8 !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_res2 got s=%h c=%b exp s=80 c=0", sum8, cout8);
        end
      end
    end
    v8 = 1'b0;
    tests_run++;
    if (!got1 || !got2) begin
      tests_failed++;
      $display("FAIL b2b_timeout got res1=%0d res2=%0d exp 1 1", got1, got2);
    end
    tests_run++;
    if (acc2 - acc1 !== W + 2) begin
      tests_failed++;
      $display("FAIL b2b_spacing got %0d exp %0d", acc2 - acc1, W + 2);
    end
    tests_run++;
    if (r1c - acc1 !== W || r2c - acc2 !== W) begin
      tests_failed++;
      $display("FAIL b2b_latency got %0d/%0d exp %0d/%0d", r1c - acc1, r2c - acc2, W, W);
    end
    tick();
  endtask

  task automatic test_w1();
    iready1 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; v1 = 1'b1;
    tick();
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    tests_run++;
    if (ovalid1 !== 1'b0 || rdy1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL w1_run got v=%b r=%b exp v=0 r=0", ovalid1, rdy1);
    end
    tick();
    tests_run++;
    if (ovalid1 !== 1'b1 || sum1 !== 1'b1 || cout1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL w1_result got v=%b s=%b c=%b exp v=1 s=1 c=1", ovalid1, sum1, cout1);
    end
    tick();
    tests_run++;
    if (ovalid1 !== 1'b0 || rdy1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL w1_handshake got v=%b r=%b exp v=0 r=1", ovalid1, rdy1);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; iready8 = 1'b0;
    v1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; iready1 = 1'b0;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_w1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
